if_pc_ctrl: RTL and testbench

IF_PC_CTRL -- requirements
Module: if_pc_ctrl

---
 rtl/if_pc_ctrl.sv | 135 +++++++++++++
 tb/tb_if_pc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller: owns the fetch PC, drives a single-outstanding
// SRAM-like fetch bus and presents one instruction at a time to ID.
module if_pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        exc_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_adel_q, if_adel_d;

  logic        redir;
  logic [31:0] redir_target;
  logic        misaligned;

  assign redir      = exc_i | eret_i | br_taken_i;
  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    redir_target = br_target_i;
    if (exc_i) begin
      redir_target = EXC_VECTOR;
    end else if (eret_i) begin
      redir_target = epc_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if_inst_d = if_inst_q;
    if_pc_d   = if_pc_q;
    if_adel_d = if_adel_q;
    case (state_q)
      S_REQ: begin
        if (redir) begin
          pc_d = redir_target;
        end
        if (misaligned) begin
          // No bus request for a misaligned PC; surface it as an address error.
          if (!redir) begin
            state_d   = S_OUT;
            if_pc_d   = pc_q;
            if_inst_d = 32'h0;
            if_adel_d = 1'b1;
          end
        end else if (inst_addr_ok) begin
          state_d   = S_WAIT;
          discard_d = redir;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d = redir_target;
        end
        if (inst_data_ok) begin
          if (discard_q || redir) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            state_d   = S_OUT;
            if_inst_d = inst_rdata;
            if_pc_d   = pc_q;
            if_adel_d = 1'b0;
          end
        end else if (redir) begin
          discard_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redir) begin
          pc_d    = redir_target;
          state_d = S_REQ;
        end else if (!stall_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_VECTOR;
      discard_q <= 1'b0;
      if_inst_q <= 32'h0;
      if_pc_q   <= 32'h0;
      if_adel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if_inst_q <= if_inst_d;
      if_pc_q   <= if_pc_d;
      if_adel_q <= if_adel_d;
    end
  end

  // Request is gated by rst so nothing is issued while reset is held.
  assign inst_req  = !rst && (state_q == S_REQ) && !misaligned;
  assign inst_addr = pc_q;
  assign if_valid  = (state_q == S_OUT);
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_adel   = if_adel_q;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed testbench for if_pc_ctrl: linear stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_if_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        exc_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int n_total = 0;
  int n_pass  = 0;

  if_pc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .exc_i        (exc_i),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr_inputs();
    stall_i      = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = 32'h0;
    eret_i       = 1'b0;
    epc_i        = 32'h0;
    exc_i        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    tick();
    tick();
    // Reset state
    chk("rst_req",   {31'b0, inst_req}, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_adel",  {31'b0, if_adel},  32'h0);
    chk("rst_inst",  if_inst, 32'h0);
    chk("rst_ifpc",  if_pc,   32'h0);

    // First fetch after reset release
    rst = 1'b0;
    #1;
    chk("rel_req",  {31'b0, inst_req}, 32'h1);
    chk("rel_addr", inst_addr, 32'hBFC00000);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("wait_req", {31'b0, inst_req}, 32'h0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h24080001;
    tick();
    clr_inputs();
    chk("out_valid", {31'b0, if_valid}, 32'h1);
    chk("out_pc",    if_pc,   32'hBFC00000);
    chk("out_inst",  if_inst, 32'h24080001);
    chk("out_adel",  {31'b0, if_adel}, 32'h0);

    // Stall holds the presented instruction
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'b0, if_valid}, 32'h1);
      chk("stall_pc",    if_pc,   32'hBFC00000);
      chk("stall_inst",  if_inst, 32'h24080001);
    end
    stall_i = 1'b0;
    tick();
    chk("cons_valid", {31'b0, if_valid}, 32'h0);
    chk("cons_req",   {31'b0, inst_req}, 32'h1);
    chk("cons_addr",  inst_addr, 32'hBFC00004);

    // Unexpected data_ok in REQ is ignored
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEADBEEF;
    tick();
    clr_inputs();
    chk("ign_valid", {31'b0, if_valid}, 32'h0);
    chk("ign_req",   {31'b0, inst_req}, 32'h1);

    // Branch in WAIT, then data_ok is dropped
    inst_addr_ok = 1'b1;
    tick();
    clr_inputs();
    br_taken_i  = 1'b1;
    br_target_i = 32'hBFC00100;
    tick();
    clr_inputs();
    chk("brw_valid", {31'b0, if_valid}, 32'h0);
    chk("brw_req",   {31'b0, inst_req}, 32'h0);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h11111111;
    tick();
    clr_inputs();
    chk("brw_drop", {31'b0, if_valid}, 32'h0);
    chk("brw_req2", {31'b0, inst_req}, 32'h1);
    chk("brw_addr", inst_addr, 32'hBFC00100);

    // Redirect priority
    exc_i       = 1'b1;
    eret_i      = 1'b1;
    epc_i       = 32'hBFC00040;
    br_taken_i  = 1'b1;
    br_target_i = 32'hBFC00200;
    tick();
    clr_inputs();
    chk("prio_addr", inst_addr, 32'hBFC00380);
    chk("prio_req",  {31'b0, inst_req}, 32'h1);

    // ERET to a misaligned EPC
    eret_i = 1'b1;
    epc_i  = 32'hBFC00042;
    tick();
    clr_inputs();
    chk("adel_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    chk("adel_valid", {31'b0, if_valid}, 32'h1);
    chk("adel_flag",  {31'b0, if_adel},  32'h1);
    chk("adel_pc",    if_pc,   32'hBFC00042);
    chk("adel_inst",  if_inst, 32'h0);

    // Redirect in OUT drops the instruction
    stall_i     = 1'b1;
    br_taken_i  = 1'b1;
    br_target_i = 32'hBFC00010;
    tick();
    clr_inputs();
    chk("bro_valid", {31'b0, if_valid}, 32'h0);
    chk("bro_addr",  inst_addr, 32'hBFC00010);

    // Redirect in REQ coincident with addr_ok
    inst_addr_ok = 1'b1;
    br_taken_i   = 1'b1;
    br_target_i  = 32'hBFC00020;
    tick();
    clr_inputs();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h22222222;
    tick();
    clr_inputs();
    chk("brr_drop", {31'b0, if_valid}, 32'h0);
    chk("brr_addr", inst_addr, 32'hBFC00020);

    // Clean fetch after discard
    inst_addr_ok = 1'b1;
    tick();
    clr_inputs();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h12345678;
    tick();
    clr_inputs();
    chk("f2_valid", {31'b0, if_valid}, 32'h1);
    chk("f2_pc",    if_pc,   32'hBFC00020);
    chk("f2_inst",  if_inst, 32'h12345678);

    // Exception coincident with data_ok in WAIT
    tick();
    chk("f3_addr", inst_addr, 32'hBFC00024);
    inst_addr_ok = 1'b1;
    tick();
    clr_inputs();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h33333333;
    exc_i        = 1'b1;
    tick();
    clr_inputs();
    chk("exw_valid", {31'b0, if_valid}, 32'h0);
    chk("exw_addr",  inst_addr, 32'hBFC00380);
    inst_addr_ok = 1'b1;
    tick();
    clr_inputs();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h44444444;
    tick();
    clr_inputs();
    chk("exw_valid2", {31'b0, if_valid}, 32'h1);
    chk("exw_pc",     if_pc,   32'hBFC00380);
    chk("exw_inst",   if_inst, 32'h44444444);

    // Reset mid-transaction, late data_ok ignored
    tick();
    inst_addr_ok = 1'b1;
    tick();
    clr_inputs();
    rst = 1'b1;
    #1;
    chk("mrst_req",  {31'b0, inst_req}, 32'h0);
    chk("mrst_addr", inst_addr, 32'hBFC00000);
    tick();
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h55555555;
    tick();
    clr_inputs();
    chk("late_valid", {31'b0, if_valid}, 32'h0);
    chk("late_req",   {31'b0, inst_req}, 32'h1);
    chk("late_addr",  inst_addr, 32'hBFC00000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
